// File: rtl/rf_fetch_mac.sv
// Fetches up to ten feature bytes at latched addresses and accumulates their
// products with signed per-entry weights into a 20-bit signed dot product.
module rf_fetch_mac (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [9:0][2:0][6:0]  i_RF,
   input  logic [3:0]            i_length,
   input  logic [9:0][7:0]       i_weight,
   output logic                  o_mem_req,
   output logic [6:0]            o_mem_row,
   output logic [6:0]            o_mem_col,
   output logic [6:0]            o_mem_ch,
   input  logic [7:0]            i_mem_data,
   output logic [19:0]           o_sum,
   output logic                  o_valid,
   output logic                  o_busy
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t               state_q, state_d;
   logic [9:0][2:0][6:0] rf_q;
   logic [9:0][7:0]      w_q;
   logic [3:0]           n_q;
   logic [3:0]           idx_q;
   logic [3:0]           widx_q;
   logic                 mem_vld;
   logic [19:0]          acc_q;
   logic [3:0]           len_c;
   logic                 accept;
   logic signed [16:0]   prod;

   assign len_c  = (i_length > 4'd10) ? 4'd10 : i_length;
   assign accept = (state_q == IDLE) && i_start;

   // Feature byte is unsigned, so a zero MSB turns it into a 9-bit signed operand.
   assign prod = $signed({1'b0, i_mem_data}) * $signed(w_q[widx_q]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = (len_c == 4'd0) ? DONE : FETCH;
         FETCH:   if (idx_q == n_q - 4'd1) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         rf_q    <= '0;
         w_q     <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         widx_q  <= '0;
         mem_vld <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         // Data returns one cycle after its request; remember which weight it pairs with.
         mem_vld <= (state_q == FETCH);
         widx_q  <= idx_q;
         if (accept) begin
            rf_q  <= i_RF;
            w_q   <= i_weight;
            n_q   <= len_c;
            idx_q <= '0;
            acc_q <= '0;
         end else begin
            if (state_q == FETCH) idx_q <= idx_q + 4'd1;
            if (mem_vld) acc_q <= acc_q + {{3{prod[16]}}, prod};
         end
      end
   end

   assign o_mem_req = (state_q == FETCH);
   assign o_mem_row = o_mem_req ? rf_q[idx_q][2] : 7'd0;
   assign o_mem_col = o_mem_req ? rf_q[idx_q][1] : 7'd0;
   assign o_mem_ch  = o_mem_req ? rf_q[idx_q][0] : 7'd0;
   assign o_valid   = (state_q == DONE);
   assign o_busy    = (state_q != IDLE);
   assign o_sum     = acc_q;

endmodule

// File: tb/tb_rf_fetch_mac.sv
// Directed bench for rf_fetch_mac: a cycle-stepped memory responder plus
// hand-computed dot products and request/valid timing.
module tb_rf_fetch_mac;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic                 i_start;
   logic [9:0][2:0][6:0] i_RF;
   logic [3:0]           i_length;
   logic [9:0][7:0]      i_weight;
   logic                 o_mem_req;
   logic [6:0]           o_mem_row, o_mem_col, o_mem_ch;
   logic [7:0]           i_mem_data;
   logic [19:0]          o_sum;
   logic                 o_valid, o_busy;

   int checks = 0;
   int errors = 0;
   int rcnt;
   int mem_vals [10];
   int rf_exp [10][3];

   rf_fetch_mac dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_RF(i_RF),
      .i_length(i_length), .i_weight(i_weight), .o_mem_req(o_mem_req),
      .o_mem_row(o_mem_row), .o_mem_col(o_mem_col), .o_mem_ch(o_mem_ch),
      .i_mem_data(i_mem_data), .o_sum(o_sum), .o_valid(o_valid), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle; answer a request seen in the previous cycle with the next memory value.
   task automatic tick();
      logic req_prev;
      req_prev = o_mem_req;
      @(posedge i_clk);
      #1;
      if (req_prev) begin
         i_mem_data = 8'(mem_vals[rcnt]);
         rcnt++;
      end else begin
         i_mem_data = 8'hA5;
      end
   endtask

   task automatic load_rf(input int n);
      for (int j = 0; j < 10; j++) begin
         i_RF[j][2] = 7'(rf_exp[j][0]);
         i_RF[j][1] = 7'(rf_exp[j][1]);
         i_RF[j][0] = 7'(rf_exp[j][0] + rf_exp[j][1] + rf_exp[j][2] - rf_exp[j][0] - rf_exp[j][1]);
      end
   endtask

   // Starts an operation from IDLE and follows it to its DONE cycle.
   task automatic run_op(input string tag, input int n, input int lenin, input int exp_sum, input bit pulse);
      int reqs;
      reqs = 0;
      rcnt = 0;
      load_rf(n);
      i_length = 4'(lenin);
      i_start = 1'b1;
      tick();
      // Inputs after the accepting edge must not matter.
      i_RF = {$urandom, $urandom, $urandom};
      i_weight = {$urandom, $urandom, $urandom};
      i_length = 4'($urandom_range(0, 15));
      for (int c = 1; c <= n + 2; c++) begin
         if (n == 0 && c == 2) break;
         chk({tag, " req"}, 32'(o_mem_req), 32'(c <= n));
         chk({tag, " valid"}, 32'(o_valid), 32'(c == ((n == 0) ? 1 : n + 2)));
         chk({tag, " busy"}, 32'(o_busy), 32'd1);
         if (o_mem_req) begin
            reqs++;
            chk({tag, " row"}, 32'(o_mem_row), rf_exp[c-1][0]);
            chk({tag, " col"}, 32'(o_mem_col), rf_exp[c-1][1]);
            chk({tag, " ch"},  32'(o_mem_ch),  rf_exp[c-1][2]);
         end else begin
            chk({tag, " addr0"}, 32'({o_mem_row, o_mem_col, o_mem_ch}), 32'd0);
         end
         if (o_valid) chk({tag, " sum"}, $signed(o_sum), exp_sum);
         i_start = pulse && (c == 1 || c == ((n == 0) ? 1 : n + 2));
         if (c < ((n == 0) ? 1 : n + 2)) tick();
      end
      chk({tag, " nreq"}, reqs, n);
   endtask

   task automatic check_idle(input string tag, input int exp_sum);
      chk({tag, " idle busy"}, 32'(o_busy), 32'd0);
      chk({tag, " idle valid"}, 32'(o_valid), 32'd0);
      chk({tag, " idle req"}, 32'(o_mem_req), 32'd0);
      chk({tag, " idle sum"}, $signed(o_sum), exp_sum);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_RF = '0;
      i_length = '0;
      i_weight = '0;
      i_mem_data = '0;
      rcnt = 0;
      for (int j = 0; j < 10; j++) begin
         mem_vals[j] = 0;
         rf_exp[j][0] = 0; rf_exp[j][1] = 0; rf_exp[j][2] = 0;
      end
      tick();
      tick();
      check_idle("reset", 0);
      chk("reset addr", 32'({o_mem_row, o_mem_col, o_mem_ch}), 32'd0);
      i_rst_n = 1'b1;

      // N=3: 10*2 + 20*-1 + 30*3 = 90
      rf_exp[0] = '{0, 1, 2}; rf_exp[1] = '{3, 4, 5}; rf_exp[2] = '{6, 7, 8};
      mem_vals[0] = 10; mem_vals[1] = 20; mem_vals[2] = 30;
      i_weight = '0;
      i_weight[0] = 8'sd2; i_weight[1] = -8'sd1; i_weight[2] = 8'sd3;
      run_op("n3", 3, 3, 90, 1'b0);
      tick();
      check_idle("n3", 90);
      tick();
      check_idle("n3 hold", 90);

      // N=10 extreme: 10 * 255 * -128 = -326400
      for (int j = 0; j < 10; j++) begin
         rf_exp[j] = '{j + 100, 127 - j, j * 3};
         mem_vals[j] = 255;
         i_weight[j] = 8'h80;
      end
      run_op("n10", 10, 10, -326400, 1'b0);
      tick();
      check_idle("n10", -326400);

      // Length 13 clamps to 10
      for (int j = 0; j < 10; j++) i_weight[j] = 8'h80;
      run_op("len13", 10, 13, -326400, 1'b0);
      tick();
      check_idle("len13", -326400);

      // N=0: immediate DONE with zero sum
      run_op("n0", 0, 0, 0, 1'b0);
      tick();
      check_idle("n0", 0);

      // Start pulses during FETCH and DONE are ignored: 1*4 + 2*5 = 14
      rf_exp[0] = '{9, 8, 7}; rf_exp[1] = '{1, 2, 3};
      mem_vals[0] = 1; mem_vals[1] = 2;
      i_weight[0] = 8'sd4; i_weight[1] = 8'sd5;
      run_op("busy", 2, 2, 14, 1'b1);
      tick();
      check_idle("busy", 14);
      // Back-to-back from IDLE, accumulator cleared: 7 * -2 = -14
      rf_exp[0] = '{11, 22, 33};
      mem_vals[0] = 7;
      i_weight[0] = 8'hFE;
      run_op("b2b", 1, 1, -14, 1'b0);
      tick();
      check_idle("b2b", -14);

      // Reset in cycle 2 of an N=5 operation
      for (int j = 0; j < 5; j++) begin
         rf_exp[j] = '{j + 1, j + 2, j + 3};
         mem_vals[j] = 50;
         i_weight[j] = 8'sd1;
      end
      rcnt = 0;
      load_rf(5);
      i_length = 4'd5;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      check_idle("rst mid", 0);
      chk("rst mid addr", 32'({o_mem_row, o_mem_col, o_mem_ch}), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rst no valid", 32'(o_valid), 32'd0);
      end
      // Single product after reset: 100 * -3 = -300
      rf_exp[0] = '{5, 6, 7};
      mem_vals[0] = 100;
      i_weight[0] = 8'hFD;
      run_op("post rst", 1, 1, -300, 1'b0);
      tick();
      check_idle("post rst", -300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
